// File: rtl/dec_host_sched.sv
// Host-side sequencer for the decision-tree engine: turns table writes and sample
// requests into DEC input traffic, guards config/inference hazards, and collects results.
module dec_host_sched #(
    parameter int MAX_INFLIGHT = 16,
    parameter int SETTLE       = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_tbl,
    input  logic [8:0]       cfg_addr,
    input  logic [7:0]       cfg_data,
    input  logic             cfg_last,
    input  logic             smp_valid,
    output logic             smp_ready,
    input  logic [63:0]      smp_feat,
    input  logic [11:0]      smp_id,
    output logic             dec_valid,
    input  logic             dec_ready,
    output logic [1:0]       dec_mode,
    output logic [63:0]      dec_data,
    output logic [11:0]      dec_id,
    input  logic             dec_out_valid,
    input  logic [11:0]      dec_out_id,
    input  logic             dec_out,
    output logic             res_valid,
    output logic [11:0]      res_id,
    output logic             res_class,
    output logic             busy,
    output logic             tree_loaded,
    output logic [1:0]       err_sticky,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_DRAIN,
        S_SETTLE,
        S_RUN
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_dec_valid;
    logic [1:0]      r_dec_mode;
    logic [63:0]     r_dec_data;
    logic [11:0]     r_dec_id;
    logic [IW-1:0]   r_inflight;
    logic [SW-1:0]   r_settle_cnt;
    logic            r_res_valid;
    logic [11:0]     r_res_id;
    logic            r_res_class;
    logic            r_tree_loaded;
    logic [1:0]      r_err;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_done;

    logic            w_oreg_free;
    logic            w_dec_hs;
    logic            w_smp_hs;
    logic            w_pending_smp;
    logic [IW:0]     w_occupancy;
    logic            w_room;
    logic            w_cfg_rdy;
    logic            w_smp_rdy;
    logic            w_cfg_acc;
    logic            w_smp_acc;
    logic            w_cfg_load;
    logic            w_smp_load;
    logic            w_drained;
    logic            w_settle_done;

    assign w_oreg_free   = !r_dec_valid || dec_ready;
    assign w_dec_hs      = r_dec_valid && dec_ready;
    assign w_smp_hs      = w_dec_hs && (r_dec_mode == 2'b11);
    assign w_pending_smp = r_dec_valid && (r_dec_mode == 2'b11);
    // A sample parked in the output register already holds a slot, so it counts
    // toward the limit before its handshake; otherwise the limit could be overrun by one.
    assign w_occupancy   = {1'b0, r_inflight} + {{IW{1'b0}}, w_pending_smp};
    assign w_room        = w_occupancy < (IW+1)'(MAX_INFLIGHT);
    assign w_cfg_rdy     = (r_state == S_CFG) && w_oreg_free;
    assign w_smp_rdy     = (r_state == S_RUN) && !cfg_valid && w_oreg_free && w_room;
    assign w_cfg_acc     = cfg_valid && w_cfg_rdy;
    assign w_smp_acc     = smp_valid && w_smp_rdy;
    assign w_cfg_load    = w_cfg_acc && (cfg_tbl != 2'b11);
    assign w_smp_load    = w_smp_acc && (smp_id != 12'd0);
    assign w_drained     = (r_inflight == '0) && !r_dec_valid;
    assign w_settle_done = (SETTLE <= 1) || (r_settle_cnt == SW'(SETTLE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_valid) begin
                    w_next = w_drained ? S_CFG : S_DRAIN;
                end else if (smp_valid && r_tree_loaded) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (cfg_valid) begin
                    w_next = S_DRAIN;
                end else if (!smp_valid && w_drained) begin
                    w_next = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    w_next = S_CFG;
                end
            end
            S_CFG: begin
                if (w_cfg_acc && cfg_last) begin
                    w_next = S_SETTLE;
                end else if (!cfg_valid) begin
                    w_next = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (!r_dec_valid && w_settle_done) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Only cycles with no DEC traffic count toward the settle window, so the
    // final config write must complete its handshake before counting starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt <= '0;
        end else if (r_state == S_SETTLE) begin
            if (!r_dec_valid) begin
                r_settle_cnt <= w_settle_done ? '0 : r_settle_cnt + SW'(1);
            end
        end else begin
            r_settle_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_valid <= 1'b0;
            r_dec_mode  <= 2'b00;
            r_dec_data  <= 64'd0;
            r_dec_id    <= 12'd0;
        end else if (w_cfg_load) begin
            r_dec_valid <= 1'b1;
            r_dec_mode  <= cfg_tbl;
            r_dec_data  <= {40'd0, 7'd0, cfg_addr[8], cfg_addr[7:0], cfg_data};
            r_dec_id    <= 12'd0;
        end else if (w_smp_load) begin
            r_dec_valid <= 1'b1;
            r_dec_mode  <= 2'b11;
            r_dec_data  <= smp_feat;
            r_dec_id    <= smp_id;
        end else if (dec_ready) begin
            r_dec_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_smp_hs, dec_out_valid})
                2'b10:   r_inflight <= r_inflight + IW'(1);
                2'b01:   r_inflight <= (r_inflight == '0) ? '0 : r_inflight - IW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid   <= 1'b0;
            r_res_id      <= 12'd0;
            r_res_class   <= 1'b0;
            r_issued      <= '0;
            r_done        <= '0;
            r_tree_loaded <= 1'b0;
            r_err         <= 2'b00;
        end else begin
            r_res_valid <= dec_out_valid;
            if (dec_out_valid) begin
                r_res_id    <= dec_out_id;
                r_res_class <= dec_out;
                r_done      <= r_done + CNT_W'(1);
            end
            if (w_smp_hs) begin
                r_issued <= r_issued + CNT_W'(1);
            end
            // Any non-final write means a new load is underway, so the old tree is invalid.
            if (w_cfg_acc) begin
                r_tree_loaded <= cfg_last;
            end
            if (w_cfg_acc && (cfg_tbl == 2'b11)) begin
                r_err[0] <= 1'b1;
            end
            if (w_smp_acc && (smp_id == 12'd0)) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    assign cfg_ready   = w_cfg_rdy;
    assign smp_ready   = w_smp_rdy;
    assign dec_valid   = r_dec_valid;
    assign dec_mode    = r_dec_mode;
    assign dec_data    = r_dec_data;
    assign dec_id      = r_dec_id;
    assign res_valid   = r_res_valid;
    assign res_id      = r_res_id;
    assign res_class   = r_res_class;
    assign busy        = (r_state != S_IDLE) || (r_inflight != '0);
    assign tree_loaded = r_tree_loaded;
    assign err_sticky  = r_err;
    assign issued_cnt  = r_issued;
    assign done_cnt    = r_done;

endmodule

// File: tb/tb_dec_host_sched.sv
// Scoreboard bench for dec_host_sched: expected DEC traffic and results are queued
// by the stimulus tasks and popped by a negedge monitor.
module tb_dec_host_sched;

    localparam int MAXI  = 2;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [1:0]       cfg_tbl = 2'b00;
    logic [8:0]       cfg_addr = 9'd0;
    logic [7:0]       cfg_data = 8'd0;
    logic             cfg_last = 1'b0;
    logic             smp_valid = 1'b0;
    logic             smp_ready;
    logic [63:0]      smp_feat = 64'd0;
    logic [11:0]      smp_id = 12'd0;
    logic             dec_valid;
    logic             dec_ready = 1'b1;
    logic [1:0]       dec_mode;
    logic [63:0]      dec_data;
    logic [11:0]      dec_id;
    logic             dec_out_valid = 1'b0;
    logic [11:0]      dec_out_id = 12'd0;
    logic             dec_out = 1'b0;
    logic             res_valid;
    logic [11:0]      res_id;
    logic             res_class;
    logic             busy;
    logic             tree_loaded;
    logic [1:0]       err_sticky;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] done_cnt;

    int errors = 0;
    int checks = 0;

    logic [77:0] decQ[$];
    logic [12:0] resQ[$];
    logic [77:0] monDec;
    logic [12:0] monRes;

    dec_host_sched #(
        .MAX_INFLIGHT(MAXI),
        .SETTLE(3),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_tbl(cfg_tbl),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .cfg_last(cfg_last),
        .smp_valid(smp_valid),
        .smp_ready(smp_ready),
        .smp_feat(smp_feat),
        .smp_id(smp_id),
        .dec_valid(dec_valid),
        .dec_ready(dec_ready),
        .dec_mode(dec_mode),
        .dec_data(dec_data),
        .dec_id(dec_id),
        .dec_out_valid(dec_out_valid),
        .dec_out_id(dec_out_id),
        .dec_out(dec_out),
        .res_valid(res_valid),
        .res_id(res_id),
        .res_class(res_class),
        .busy(busy),
        .tree_loaded(tree_loaded),
        .err_sticky(err_sticky),
        .issued_cnt(issued_cnt),
        .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expV);
        checks++;
        if (act !== expV) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expV);
        end
    endtask

    // DEC handshakes and result pulses are checked against the queued expectations.
    always @(negedge clk) begin
        if (!rst && dec_valid && dec_ready) begin
            if (decQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL dec_unexpected: got mode %0d id %0d data 0x%0h, expected no traffic",
                         dec_mode, dec_id, dec_data);
            end else begin
                monDec = decQ.pop_front();
                checkOutput("dec_mode", 64'(dec_mode), 64'(monDec[77:76]));
                checkOutput("dec_data", dec_data, monDec[75:12]);
                checkOutput("dec_id", 64'(dec_id), 64'(monDec[11:0]));
            end
        end
        if (!rst && res_valid) begin
            if (resQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL res_unexpected: got id %0d class %0d, expected no result", res_id, res_class);
            end else begin
                monRes = resQ.pop_front();
                checkOutput("res_id", 64'(res_id), 64'(monRes[11:0]));
                checkOutput("res_class", 64'(res_class), 64'(monRes[12]));
            end
        end
    end

    task automatic waitReady(input bit isCfg, input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (isCfg ? cfg_ready : smp_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: got no ready within 200 cycles, expected accept", name);
        end
        @(posedge clk);
        #1;
        if (isCfg) cfg_valid = 1'b0;
        else smp_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [1:0] tbl, input logic [8:0] addr, input logic [7:0] data,
                                 input logic last, input bit expTraffic, input logic [1:0] expMode,
                                 input logic [63:0] expData);
        if (expTraffic) decQ.push_back({expMode, expData, 12'd0});
        cfg_tbl   = tbl;
        cfg_addr  = addr;
        cfg_data  = data;
        cfg_last  = last;
        cfg_valid = 1'b1;
        waitReady(1'b1, "cfg_accept");
    endtask

    task automatic driveSample(input logic [63:0] feat, input logic [11:0] id);
        if (id != 12'd0) decQ.push_back({2'b11, feat, id});
        smp_feat  = feat;
        smp_id    = id;
        smp_valid = 1'b1;
    endtask

    task automatic applySample(input logic [63:0] feat, input logic [11:0] id);
        driveSample(feat, id);
        waitReady(1'b0, "smp_accept");
    endtask

    task automatic applyResult(input logic [11:0] id, input logic cls);
        resQ.push_back({cls, id});
        dec_out_id    = id;
        dec_out       = cls;
        dec_out_valid = 1'b1;
        @(posedge clk);
        #1;
        dec_out_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int idleCnt;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_dec_valid", 64'(dec_valid), 64'd0);
        checkOutput("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        checkOutput("rst_smp_ready", 64'(smp_ready), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_tree_loaded", 64'(tree_loaded), 64'd0);
        checkOutput("rst_err", 64'(err_sticky), 64'd0);
        checkOutput("rst_issued", 64'(issued_cnt), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] T1 tree load");
        applyStimulus(2'd0, 9'h002, 8'd3,   1'b0, 1'b1, 2'b00, 64'h0000_0000_0000_0203);
        applyStimulus(2'd1, 9'h002, 8'd100, 1'b0, 1'b1, 2'b01, 64'h0000_0000_0000_0264);
        applyStimulus(2'd2, 9'h004, 8'd0,   1'b0, 1'b1, 2'b10, 64'h0000_0000_0000_0400);
        applyStimulus(2'd2, 9'h105, 8'd1,   1'b1, 1'b1, 2'b10, 64'h0000_0000_0001_0501);
        checkOutput("t1_tree_loaded", 64'(tree_loaded), 64'd1);
        idleCnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (!dec_valid) idleCnt++;
        end
        checkOutput("t1_settle_idle_cycles", 64'(idleCnt), 64'd3);
        checkOutput("t1_idle_after_settle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] T2 single inference");
        applySample(64'h0000_0000_3200_0000, 12'd7);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t2_busy_inflight", 64'(busy), 64'd1);
        applyResult(12'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t2_issued", 64'(issued_cnt), 64'd1);
        checkOutput("t2_done", 64'(done_cnt), 64'd1);
        checkOutput("t2_busy_done", 64'(busy), 64'd0);

        $display("[TB] T3 backpressure");
        dec_ready = 1'b0;
        applySample(64'h0102_0304_0506_0708, 12'd8);
        driveSample(64'h1111_2222_3333_4444, 12'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t3_smp_ready_held", 64'(smp_ready), 64'd0);
            checkOutput("t3_dec_data_stable", dec_data, 64'h0102_0304_0506_0708);
            checkOutput("t3_dec_id_stable", 64'(dec_id), 64'd8);
        end
        @(posedge clk);
        #1;
        dec_ready = 1'b1;
        waitReady(1'b0, "t3_smp_accept");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t3_issued", 64'(issued_cnt), 64'd3);
        applyResult(12'd8, 1'b1);
        applyResult(12'd9, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] T4 inflight limit");
        applySample(64'hA1A1_0000_0000_0015, 12'd21);
        applySample(64'hB2B2_0000_0000_0016, 12'd22);
        driveSample(64'hC3C3_0000_0000_0017, 12'd23);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("t4_smp_ready_full", 64'(smp_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("t4_issued_at_limit", 64'(issued_cnt), 64'd5);
        applyResult(12'd21, 1'b1);
        waitReady(1'b0, "t4_third_accept");
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] T5 drain before config");
        decQ.push_back({2'b00, 64'h0000_0000_0000_0709, 12'd0});
        cfg_tbl   = 2'd0;
        cfg_addr  = 9'h007;
        cfg_data  = 8'd9;
        cfg_last  = 1'b1;
        cfg_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t5_cfg_ready_drain", 64'(cfg_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        applyResult(12'd22, 1'b0);
        @(negedge clk);
        checkOutput("t5_cfg_ready_one_left", 64'(cfg_ready), 64'd0);
        @(posedge clk);
        #1;
        applyResult(12'd23, 1'b1);
        waitReady(1'b1, "t5_cfg_accept");
        repeat (10) @(posedge clk);
        #1;
        checkOutput("t5_issued", 64'(issued_cnt), 64'd6);
        checkOutput("t5_done", 64'(done_cnt), 64'd6);
        checkOutput("t5_tree_loaded", 64'(tree_loaded), 64'd1);

        $display("[TB] T6 error handling");
        applySample(64'hDEAD_BEEF_0000_0000, 12'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t6_no_dec_smp0", 64'(dec_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        applyStimulus(2'd3, 9'h011, 8'd55, 1'b0, 1'b0, 2'b00, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("t6_no_dec_tbl3", 64'(dec_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("t6_err_sticky", 64'(err_sticky), 64'd3);
        checkOutput("t6_issued_unchanged", 64'(issued_cnt), 64'd6);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6_err_cleared", 64'(err_sticky), 64'd0);
        checkOutput("t6_tree_cleared", 64'(tree_loaded), 64'd0);
        checkOutput("t6_issued_cleared", 64'(issued_cnt), 64'd0);
        checkOutput("t6_done_cleared", 64'(done_cnt), 64'd0);
        checkOutput("t6_busy_cleared", 64'(busy), 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        checkOutput("dec_queue_empty", 64'(decQ.size()), 64'd0);
        checkOutput("res_queue_empty", 64'(resQ.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
